// File: rtl/lut_seq_pkg.sv
// Shared types and constants for the program-table sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the boundary-decision encoding and the bit
// positions of the 40-bit table entry {duration, ctrl, aux, pattern}.
package lut_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RUN,
    ST_DONE
  } state_e;

  // Outcome of the load check applied to lut_dout at an entry boundary.
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_LOAD,
    ACT_TERM,
    ACT_ERR
  } bnd_act_e;

  localparam int ENTRY_W  = 40;
  localparam int DUR_MSB  = 39;
  localparam int DUR_LSB  = 16;
  localparam int CTRL_MSB = 15;
  localparam int CTRL_LSB = 12;
  localparam int AUX_MSB  = 11;
  localparam int AUX_LSB  = 8;
  localparam int PAT_MSB  = 7;
  localparam int PAT_LSB  = 0;

  // Matches the pattern of the table's default (terminator) entry.
  localparam logic [7:0] IDLE_PAT_DEF = 8'h55;

endpackage

// File: rtl/seq_dur_counter.sv
// Loadable down-counter timing how long the current entry stays on the outputs.
// Latency: load/clear take effect at the next edge; last is combinational from the count.
// Backpressure: none; clr beats load, load beats the decrement.
//
// Ports:
//   clk, rst_n      clock, async active-low reset (count resets to 0)
//   clr             force the count to 0
//   load, load_val  load a new duration
//   en              decrement while the count is non-zero
//   last            high when the count is 1 (final cycle of the entry)
module seq_dur_counter #(
  parameter int unsigned DUR_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [DUR_W-1:0] cnt_q;
  logic [DUR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == DUR_W'(1));

endmodule

// File: rtl/lut_sequencer.sv
// Walks a combinational program table from BASE_ADDR, holding each entry's fields for `duration` cycles.
// Latency: start at edge 0 -> FETCH in cycle 1 -> first entry on outputs from edge 2; no bubble between entries.
// Backpressure: none; start is ignored while busy, abort returns to IDLE at the next edge and beats start.
//
// Optional feature: define LUT_SEQ_LOOP_EN to add the `loop` input, which restarts the
// program at BASE_ADDR instead of finishing when a terminator is reached.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, abort, loop         run request, synchronous stop, restart-at-terminator
//   lut_addr / lut_dout        registered table address / combinational table data
//   lut_vital                  table-valid flag for the addressed entry
//   ctrl_out, aux_out, pat_out held fields of the current entry (idle: 0, 0, IDLE_PAT)
//   busy, done, err            FETCH/RUN flag, completion pulse, sticky error
module lut_sequencer
  import lut_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 20,
  parameter int unsigned       DUR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(1),
  parameter logic [7:0]        IDLE_PAT  = IDLE_PAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
`ifdef LUT_SEQ_LOOP_EN
  input  logic               loop,
`endif
  output logic [ADDR_W-1:0]  lut_addr,
  input  logic [ENTRY_W-1:0] lut_dout,
  input  logic               lut_vital,
  output logic [3:0]         ctrl_out,
  output logic [3:0]         aux_out,
  output logic [7:0]         pat_out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wrap_q;   // entry at the top address has been loaded
  logic [3:0]        ctrl_q;
  logic [3:0]        aux_q;
  logic [7:0]        pat_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              loop_en;
  logic [DUR_W-1:0]  dur_f;
  logic              cnt_last;
  logic              boundary;
  bnd_act_e          act;

`ifdef LUT_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign dur_f = lut_dout[DUR_MSB:DUR_LSB];

  // lut_dout already reflects the next address during the last RUN cycle,
  // so the load check there gives back-to-back entries.
  assign boundary = (state_q == ST_FETCH) || ((state_q == ST_RUN) && cnt_last);

  always_comb begin
    act = ACT_NONE;
    if (boundary) begin
      if (!lut_vital) begin
        act = ACT_ERR;
      end else if (wrap_q || (dur_f == '0)) begin
        // Past the top address the table is treated as ended rather than wrapping.
        act = ACT_TERM;
      end else begin
        act = ACT_LOAD;
      end
    end
  end

  seq_dur_counter #(
    .DUR_W (DUR_W)
  ) u_dur_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (abort || (act == ACT_TERM) || (act == ACT_ERR)),
    .load     (!abort && (act == ACT_LOAD)),
    .load_val (dur_f),
    .en       (state_q == ST_RUN),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wrap_q  <= 1'b0;
      ctrl_q  <= '0;
      aux_q   <= '0;
      pat_q   <= IDLE_PAT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      aux_q   <= '0;
      pat_q   <= IDLE_PAT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= BASE_ADDR;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH, ST_RUN: begin
          case (act)
            ACT_LOAD: begin
              ctrl_q  <= lut_dout[CTRL_MSB:CTRL_LSB];
              aux_q   <= lut_dout[AUX_MSB:AUX_LSB];
              pat_q   <= lut_dout[PAT_MSB:PAT_LSB];
              if (addr_q == '1) begin
                wrap_q <= 1'b1;
              end else begin
                addr_q <= addr_q + 1'b1;
              end
              state_q <= ST_RUN;
            end
            ACT_TERM: begin
              if (wrap_q) begin
                err_q <= 1'b1;
              end
              ctrl_q <= '0;
              aux_q  <= '0;
              pat_q  <= IDLE_PAT;
              if (loop_en) begin
                addr_q  <= BASE_ADDR;
                wrap_q  <= 1'b0;
                state_q <= ST_FETCH;
              end else begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end
            ACT_ERR: begin
              err_q   <= 1'b1;
              ctrl_q  <= '0;
              aux_q   <= '0;
              pat_q   <= IDLE_PAT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
            default: ;
          endcase
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lut_addr = addr_q;
  assign ctrl_out = ctrl_q;
  assign aux_out  = aux_q;
  assign pat_out  = pat_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_lut_sequencer.sv
module tb_lut_sequencer;

  localparam int TBL_N = 64;
  localparam logic [39:0] DEF_ENTRY = {24'd0, 4'd0, 4'd0, 8'h55};

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  ctrl;
    logic [3:0]  aux;
    logic [7:0]  pat;
    logic        addr_chk;
    logic [19:0] addr;
  } rec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
`ifdef LUT_SEQ_LOOP_EN
  logic        loop  = 1'b0;
`endif
  logic [19:0] lut_addr;
  logic [39:0] lut_dout;
  logic        lut_vital;
  logic [3:0]  ctrl_out;
  logic [3:0]  aux_out;
  logic [7:0]  pat_out;
  logic        busy;
  logic        done;
  logic        err;

  // second instance with a 3-bit address space to reach the top-address case
  logic        w_start = 1'b0;
  logic [2:0]  w_addr;
  logic [39:0] w_dout;
  logic [3:0]  w_ctrl;
  logic [3:0]  w_aux;
  logic [7:0]  w_pat;
  logic        w_busy;
  logic        w_done;
  logic        w_err;

  logic [39:0] mem [TBL_N];
  logic        vit [TBL_N];

  rec_t exp_q[$];
  logic last_idle = 1'b1;
  logic last_err  = 1'b0;
  logic tail_pend = 1'b0;
  logic chk_en    = 1'b0;
  int   total = 0;
  int   bad   = 0;

  assign lut_dout  = (lut_addr < 20'd64) ? mem[lut_addr[5:0]] : DEF_ENTRY;
  assign lut_vital = (lut_addr < 20'd64) ? vit[lut_addr[5:0]] : 1'b1;
  assign w_dout    = {24'd2, 4'h1, 4'h2, 5'd0, w_addr};

  lut_sequencer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
`ifdef LUT_SEQ_LOOP_EN
    .loop      (loop),
`endif
    .lut_addr  (lut_addr),
    .lut_dout  (lut_dout),
    .lut_vital (lut_vital),
    .ctrl_out  (ctrl_out),
    .aux_out   (aux_out),
    .pat_out   (pat_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  lut_sequencer #(
    .ADDR_W    (3),
    .BASE_ADDR (3'd5)
  ) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start),
    .abort     (1'b0),
`ifdef LUT_SEQ_LOOP_EN
    .loop      (1'b0),
`endif
    .lut_addr  (w_addr),
    .lut_dout  (w_dout),
    .lut_vital (1'b1),
    .ctrl_out  (w_ctrl),
    .aux_out   (w_aux),
    .pat_out   (w_pat),
    .busy      (w_busy),
    .done      (w_done),
    .err       (w_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic rec_t mk(input logic b, input logic d, input logic e,
                              input logic [3:0] c, input logic [3:0] a,
                              input logic [7:0] p, input logic ac, input logic [19:0] ad);
    rec_t r;
    r.busy = b; r.done = d; r.err = e; r.ctrl = c; r.aux = a;
    r.pat = p; r.addr_chk = ac; r.addr = ad;
    return r;
  endfunction

  function automatic logic loop_now();
`ifdef LUT_SEQ_LOOP_EN
    return loop;
`else
    return 1'b0;
`endif
  endfunction

  // Expand one pass of the program into per-cycle expected outputs:
  // one FETCH cycle, then `dur` cycles per entry. What follows a terminator
  // depends on `loop` at that moment, so it is decided later (tail_pend).
  function automatic void push_pass();
    int          a;
    logic [39:0] e;
    logic        v;
    a = 1;
    tail_pend = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h55, 1'b1, 20'd1));
    while (1) begin
      e = (a < TBL_N) ? mem[a] : DEF_ENTRY;
      v = (a < TBL_N) ? vit[a] : 1'b1;
      if (!v) begin
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 8'h55, 1'b0, 20'd0));
        return;
      end
      if (e[39:16] == 24'd0) begin
        tail_pend = 1'b1;
        return;
      end
      repeat (int'(e[39:16]))
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, e[15:12], e[11:8], e[7:0], 1'b1, 20'(a + 1)));
      a++;
    end
  endfunction

  always @(posedge clk) begin
    rec_t ex;
    #1;
    if (chk_en) begin
      if ((exp_q.size() == 0) && tail_pend) begin
        tail_pend = 1'b0;
        if (loop_now()) push_pass();
        else exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'h55, 1'b0, 20'd0));
      end
      if (exp_q.size() != 0) ex = exp_q.pop_front();
      else ex = mk(1'b0, 1'b0, last_err, 4'd0, 4'd0, 8'h55, 1'b0, 20'd0);
      check("outputs", {busy, done, err, ctrl_out, aux_out, pat_out},
            {ex.busy, ex.done, ex.err, ex.ctrl, ex.aux, ex.pat});
      if (ex.addr_chk) check("lut_addr", lut_addr, ex.addr);
      last_idle = !ex.busy && !ex.done;
      last_err  = ex.err;
    end
  end

  // Drive inputs for the coming edge and tell the model what the DUT will see.
  task automatic apply(input logic s, input logic a);
    start = s;
    abort = a;
    if (a) begin
      exp_q.delete();
      tail_pend = 1'b0;
    end else if (s && last_idle) begin
      push_pass();
    end
  endtask

  // Returns at the negedge of the cycle after the pulse (FETCH cycle after a start).
  task automatic go(input logic s, input logic a);
    @(negedge clk);
    apply(s, a);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < TBL_N; i++) begin
      mem[i] = DEF_ENTRY;
      vit[i] = 1'b1;
    end
  endtask

  task automatic full_prog();
    int durs [9] = '{102, 63, 95, 63, 95, 63, 95, 63, 95};
    logic [3:0] c;
    clear_tbl();
    for (int i = 1; i <= 9; i++) begin
      c = (i == 1) ? 4'b0110 : ((i % 2 == 0) ? 4'b0010 : 4'b0000);
      mem[i] = {24'(durs[i-1]), c, 4'(i), 8'(i * 17)};
    end
  endtask

  task automatic rand_prog();
    int n;
    n = $urandom_range(0, 6);
    clear_tbl();
    for (int i = 1; i <= n; i++) begin
      mem[i] = {24'($urandom_range(1, 5)), 4'($urandom), 4'($urandom), 8'($urandom)};
      vit[i] = ($urandom_range(0, 7) != 0);
    end
    vit[n + 1] = ($urandom_range(0, 7) != 0);
  endtask

  initial begin
    int bc;
    int dc;
    int pc;
    int zc;
    clear_tbl();

    // reset values
    #12;
    check("reset_outputs", {busy, done, err, ctrl_out, aux_out, pat_out},
          {1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h55});
    check("reset_addr", lut_addr, 20'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // full program
    full_prog();
    go(1'b1, 1'b0);
    bc = 0; dc = 0;
    for (int i = 0; i < 740; i++) begin
      if (busy) bc++;
      if (done) dc++;
      if (i == 1)   check("full_ctrl_first", ctrl_out, 4'b0110);
      if (i == 102) check("full_ctrl_e1_last", ctrl_out, 4'b0110);
      if (i == 103) check("full_ctrl_e2", ctrl_out, 4'b0010);
      if (i == 166) check("full_ctrl_e3", ctrl_out, 4'b0000);
      @(negedge clk);
    end
    check("full_busy_cycles", bc, 735);
    check("full_done_pulses", dc, 1);
    check("full_pat_end", pat_out, 8'h55);

    // empty program
    clear_tbl();
    go(1'b1, 1'b0);
    check("empty_no_done_fetch", done, 1'b0);
    @(negedge clk);
    check("empty_done", {done, err, pat_out}, {1'b1, 1'b0, 8'h55});
    repeat (3) @(negedge clk);

    // abort in the 50th cycle of entry 1
    full_prog();
    go(1'b1, 1'b0);
    repeat (49) @(negedge clk);
    go(1'b0, 1'b1);
    check("abort_idle", {busy, pat_out}, {1'b0, 8'h55});
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    check("abort_no_done", dc, 0);
    go(1'b1, 1'b0);
    check("restart_addr", lut_addr, 20'd1);
    repeat (740) @(negedge clk);

    // vital error at entry 3
    vit[3] = 1'b0;
    go(1'b1, 1'b0);
    repeat (166) @(negedge clk);
    check("vital_done", {done, err, busy, pat_out}, {1'b1, 1'b1, 1'b0, 8'h55});
    repeat (3) @(negedge clk);
    check("vital_err_sticky", err, 1'b1);
    vit[3] = 1'b1;
    go(1'b1, 1'b0);
    check("vital_err_cleared", err, 1'b0);
    repeat (5) @(negedge clk);
    go(1'b0, 1'b1);

    // start and abort together in IDLE
    go(1'b1, 1'b1);
    check("start_abort_idle", busy, 1'b0);
    repeat (3) @(negedge clk);

    // async reset during RUN
    go(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_reset", {busy, done, err, ctrl_out, aux_out, pat_out, lut_addr},
          {1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h55, 20'd0});
    exp_q.delete();
    tail_pend = 1'b0;
    last_idle = 1'b1;
    last_err  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

`ifdef LUT_SEQ_LOOP_EN
    // looping two-entry program
    clear_tbl();
    mem[1] = {24'd3, 4'h3, 4'h1, 8'hA1};
    mem[2] = {24'd4, 4'h4, 4'h2, 8'hB2};
    loop = 1'b1;
    go(1'b1, 1'b0);
    bc = 0; dc = 0; pc = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy) bc++;
      if (done) dc++;
      if (pat_out == 8'h55) pc++;
      @(negedge clk);
    end
    check("loop_busy", bc, 24);
    check("loop_no_done", dc, 0);
    check("loop_fetch_cycles", pc, 3);
    loop = 1'b0;
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    check("loop_drop_done", dc, 1);
`endif

    // randomized programs, starts, aborts
    for (int p = 0; p < 25; p++) begin
      go(1'b0, 1'b1);
      rand_prog();
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        apply(($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0));
`ifdef LUT_SEQ_LOOP_EN
        if ($urandom_range(0, 19) == 0) loop = ~loop;
`endif
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
    end
`ifdef LUT_SEQ_LOOP_EN
    loop = 1'b0;
`endif
    go(1'b0, 1'b1);

    // top address reached: entries 5,6,7 then forced end with err
    @(negedge clk);
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    bc = 0; dc = 0; zc = 0;
    for (int i = 0; i < 14; i++) begin
      if (w_busy) bc++;
      if (w_done) dc++;
      if (w_busy && (w_addr == 3'd0)) zc++;
      if (i == 1) check("wrap_first_pat", w_pat, 8'h05);
      @(negedge clk);
    end
    check("wrap_busy", bc, 7);
    check("wrap_done", dc, 1);
    check("wrap_no_addr0", zc, 0);
    check("wrap_err", w_err, 1'b1);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
